// File: rtl/rf_alu_sequencer.sv
// Command FIFO plus READ/EXEC/WB sequencer driving the register-file/ALU datapath
// controls; one queued command is issued every three cycles.
module rf_alu_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned OPW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPW-1:0]         cmd_op,
  input  logic [AW-1:0]          cmd_ra,
  input  logic [AW-1:0]          cmd_rb,
  input  logic [AW-1:0]          cmd_rw,
  input  logic                   cmd_we,
  output logic [AW-1:0]          rf_r_addr_a,
  output logic [AW-1:0]          rf_r_addr_b,
  output logic                   rr_en,
  output logic [OPW-1:0]         alu_op,
  output logic                   f_en,
  output logic [AW-1:0]          rf_w_addr,
  output logic                   rf_we,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = OPW + 3 * AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ready_q, busy_q;
  logic            rr_en_q, f_en_q, rf_we_q, done_q;
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   ra_q, rb_q, rw_q;
  logic            we_q;
  logic            push, pop;
  logic [EW-1:0]   head;

  assign push = cmd_valid && ready_q;
  assign head = mem_q[rd_ptr_q];

  // Next state, pop decision and FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Storage needs no reset: occupancy is tracked by level_q alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_we};
  end

  // Strobes and status are registered from the next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rr_en_q  <= 1'b0;
      f_en_q   <= 1'b0;
      rf_we_q  <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rw_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= (level_d != LW'(DEPTH));
      busy_q   <= (state_d != S_IDLE) || (level_d != '0);
      rr_en_q  <= (state_d == S_READ);
      f_en_q   <= (state_d == S_EXEC);
      rf_we_q  <= (state_d == S_WB) && we_q;
      done_q   <= (state_d == S_WB);
      if (pop) {op_q, ra_q, rb_q, rw_q, we_q} <= head;
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign level       = level_q;
  assign rr_en       = rr_en_q;
  assign f_en        = f_en_q;
  assign rf_we       = rf_we_q;
  assign done        = done_q;
  assign alu_op      = op_q;
  assign rf_r_addr_a = ra_q;
  assign rf_r_addr_b = rb_q;
  assign rf_w_addr   = rw_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Random command traffic against a schedule model: each accepted command's
// READ cycle is derived from its accept cycle and the previous command's WB.
module tb_rf_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [4:0] cmd_ra, cmd_rb, cmd_rw;
  logic       cmd_we;
  logic [4:0] rf_r_addr_a, rf_r_addr_b, rf_w_addr;
  logic       rr_en, f_en, rf_we, busy, done;
  logic [3:0] alu_op;
  logic [2:0] level;

  always #5 clk = ~clk;

  rf_alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_we(cmd_we),
    .rf_r_addr_a(rf_r_addr_a), .rf_r_addr_b(rf_r_addr_b), .rr_en(rr_en),
    .alu_op(alu_op), .f_en(f_en), .rf_w_addr(rf_w_addr), .rf_we(rf_we),
    .busy(busy), .done(done), .level(level)
  );

  typedef struct {
    int         t;
    int         r;
    logic [3:0] op;
    logic [4:0] ra, rb, rw;
    logic       we;
  } cmd_t;

  cmd_t cmdq[$];
  int   last_wb;
  int   cyc;
  int   passed;
  int   total;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    else
      passed++;
  endtask

  function automatic int model_level(input int c);
    int n = 0;
    foreach (cmdq[i]) begin
      if (cmdq[i].t + 1 <= c) n++;
      if (cmdq[i].r <= c) n--;
    end
    return n;
  endfunction

  task automatic check_cycle(input int c);
    logic       e_rr = 1'b0, e_f = 1'b0, e_done = 1'b0, e_we = 1'b0, e_act = 1'b0;
    logic [3:0] e_op = '0;
    logic [4:0] e_ra = '0, e_rb = '0, e_rw = '0;
    int         lvl;
    // Retire commands that finished and have a started successor
    while (cmdq.size() > 1 && cmdq[0].r + 2 < c && cmdq[1].r <= c) void'(cmdq.pop_front());
    foreach (cmdq[i]) begin
      if (cmdq[i].r == c) e_rr = 1'b1;
      if (cmdq[i].r + 1 == c) e_f = 1'b1;
      if (cmdq[i].r + 2 == c) begin
        e_done = 1'b1;
        e_we   = cmdq[i].we;
      end
      if (cmdq[i].r <= c && c <= cmdq[i].r + 2) e_act = 1'b1;
      if (cmdq[i].r <= c) begin
        e_op = cmdq[i].op; e_ra = cmdq[i].ra; e_rb = cmdq[i].rb; e_rw = cmdq[i].rw;
      end
    end
    lvl = model_level(c);
    check_val("rr_en", 32'(rr_en), 32'(e_rr));
    check_val("f_en", 32'(f_en), 32'(e_f));
    check_val("done", 32'(done), 32'(e_done));
    check_val("rf_we", 32'(rf_we), 32'(e_we));
    check_val("level", 32'(level), 32'(lvl));
    check_val("cmd_ready", 32'(cmd_ready), 32'(lvl != 4));
    check_val("busy", 32'(busy), 32'(e_act || lvl != 0));
    check_val("alu_op", 32'(alu_op), 32'(e_op));
    check_val("rf_r_addr_a", 32'(rf_r_addr_a), 32'(e_ra));
    check_val("rf_r_addr_b", 32'(rf_r_addr_b), 32'(e_rb));
    check_val("rf_w_addr", 32'(rf_w_addr), 32'(e_rw));
  endtask

  task automatic drive(input int c, input int prob);
    cmd_t n;
    cmd_op = 4'($urandom);
    cmd_ra = 5'($urandom);
    cmd_rb = 5'($urandom);
    cmd_rw = 5'($urandom);
    cmd_we = 1'($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 149) == 0) begin
      rst       = 1'b1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmdq.delete();
      last_wb = -100;
    end else begin
      cmd_valid = ($urandom_range(0, 99) < prob);
      if (cmd_valid && model_level(c) != 4) begin
        n.t  = c;
        n.r  = (c + 2 > last_wb + 1) ? c + 2 : last_wb + 1;
        n.op = cmd_op; n.ra = cmd_ra; n.rb = cmd_rb; n.rw = cmd_rw; n.we = cmd_we;
        last_wb = n.r + 2;
        cmdq.push_back(n);
      end
    end
  endtask

  initial begin
    int probs[3] = '{10, 50, 95};
    passed = 0; total = 0; cyc = 0; last_wb = -100;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Pushes presented while reset is held must be ignored
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_ra = 5'd3; cmd_rb = 5'd4; cmd_rw = 5'd5; cmd_we = 1'b1;
    @(posedge clk);
    #1;
    check_cycle(cyc);
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      check_cycle(cyc);
      drive(cyc, probs[(k / 200) % 3]);
      @(posedge clk);
      #1;
      cyc++;
      if (rst) rst = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
